prbs_gen: RTL and testbench

Parametrised pseudo-random bit generator for the replay buffer's scrambler and test-pattern paths, generalising the fixed 16-bit LFSR. It supports configurable width, tap polynomial and seed, and advances several bits per cycle. Output is gated by a valid/ready handshake, so downstream stalls freeze the sequence. It also provides zero-safe reloads and a one-cycle wrap pulse when the sequence returns to its start state.

---
 rtl/prbs_gen.sv | 105 ++++++++++
 tb/tb_prbs_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen.sv
// Parametrised Fibonacci LFSR pattern generator with valid/ready output,
// STEP bits of advance per accepted word, zero-safe reload and a wrap pulse
// when the sequence returns to the state captured at the last reset/load.
`timescale 1ns/1ps

module prbs_gen #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'h00FF,
  parameter int unsigned      STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             zero_fix
);

  // Reject configurations that could lock up in the all-zero state or
  // that fall outside the supported widths.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("prbs_gen: WIDTH must be in 2..32");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("prbs_gen: STEP must be in 1..WIDTH");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("prbs_gen: SEED must be nonzero");
  end
  if (TAPS == '0) begin : g_bad_taps
    $error("prbs_gen: TAPS must be nonzero");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic             wrap_q, wrap_d;
  logic             zero_fix_q, zero_fix_d;
  logic [WIDTH-1:0] adv_state;
  logic [WIDTH-1:0] load_val;
  logic             load_zero;
  logic             accept;

  // One Fibonacci shift: parity of tapped bits enters at bit 0.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // STEP single shifts unrolled into one combinational advance.
  always_comb begin
    adv_state = state_q;
    for (int i = 0; i < int'(STEP); i++) begin
      adv_state = lfsr_step(adv_state);
    end
  end

  assign load_zero = (load_data == '0);
  assign load_val  = load_zero ? SEED : load_data;
  assign out_valid = en & ~load;
  assign accept    = en & out_ready;

  // Next-state selection: load beats advance, advance beats hold.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_d    = state_q;
    start_d    = start_q;
    wrap_d     = 1'b0;
    zero_fix_d = 1'b0;
    if (load) begin
      state_d    = load_val;
      start_d    = load_val;
      zero_fix_d = load_zero;
    end else if (accept) begin
      state_d = adv_state;
      wrap_d  = (adv_state == start_q);
    end
  end

  // State, start reference and pulse registers with async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments here so all registers update together
    // from pre-edge values, independent of statement order.
    if (!rst) begin
      state_q    <= SEED;
      start_q    <= SEED;
      wrap_q     <= 1'b0;
      zero_fix_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      wrap_q     <= wrap_d;
      zero_fix_q <= zero_fix_d;
    end
  end

  assign q        = state_q;
  assign wrap     = wrap_q;
  assign zero_fix = zero_fix_q;

endmodule

// File: tb/tb_prbs_gen.sv
// Self-checking bench for prbs_gen: three instances (16-bit STEP=1,
// 16-bit STEP=4, 8-bit STEP=1) share one stimulus and are compared every
// cycle against an arithmetic reference model, plus literal expectations.
`timescale 1ns/1ps

module tb_prbs_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] load_data;
  logic        out_ready;

  logic [15:0] q_a, q_b;
  logic [7:0]  q_c;
  logic        ov_a, ov_b, ov_c;
  logic        wr_a, wr_b, wr_c;
  logic        zf_a, zf_b, zf_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prbs_gen dut_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_data(load_data),
    .out_ready(out_ready), .out_valid(ov_a), .q(q_a), .wrap(wr_a), .zero_fix(zf_a)
  );

  prbs_gen #(.STEP(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_data(load_data),
    .out_ready(out_ready), .out_valid(ov_b), .q(q_b), .wrap(wr_b), .zero_fix(zf_b)
  );

  prbs_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEP(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_data(load_data[7:0]),
    .out_ready(out_ready), .out_valid(ov_c), .q(q_c), .wrap(wr_c), .zero_fix(zf_c)
  );

  // Per-instance configuration seen by the reference model.
  int unsigned p_w[3]    = '{16, 16, 8};
  int unsigned p_taps[3] = '{32'hB400, 32'hB400, 32'hB8};
  int unsigned p_seed[3] = '{32'h00FF, 32'h00FF, 32'h01};
  int unsigned p_step[3] = '{1, 4, 1};

  // Reference model state.
  int unsigned m_state[3];
  int unsigned m_start[3];
  bit          m_wrap[3];
  bit          m_zf[3];

  function automatic int unsigned wmask(int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // One LFSR bit: shift left, parity of tapped bits as new LSB.
  function automatic int unsigned f1(int unsigned s, int unsigned taps, int unsigned w);
    int unsigned fb;
    fb = int'($countones(s & taps)) % 2;
    return ((s << 1) | fb) & wmask(w);
  endfunction

  function automatic int unsigned advance(int unsigned s, int idx);
    int unsigned r;
    r = s;
    for (int k = 0; k < int'(p_step[idx]); k++) r = f1(r, p_taps[idx], p_w[idx]);
    return r;
  endfunction

  function automatic int unsigned load_value(int idx);
    int unsigned ld;
    ld = 32'(load_data) & wmask(p_w[idx]);
    return (ld == 0) ? p_seed[idx] : ld;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model update from the specification's priority rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_state[i] <= p_seed[i];
        m_start[i] <= p_seed[i];
        m_wrap[i]  <= 1'b0;
        m_zf[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (load) begin
          m_state[i] <= load_value(i);
          m_start[i] <= load_value(i);
          m_zf[i]    <= ((32'(load_data) & wmask(p_w[i])) == 0);
          m_wrap[i]  <= 1'b0;
        end else if (en && out_ready) begin
          m_state[i] <= advance(m_state[i], i);
          m_wrap[i]  <= (advance(m_state[i], i) == m_start[i]);
          m_zf[i]    <= 1'b0;
        end else begin
          m_wrap[i] <= 1'b0;
          m_zf[i]   <= 1'b0;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  logic [31:0] q_o[3];
  logic        ov_o[3], wr_o[3], zf_o[3];
  always_comb begin
    q_o[0] = 32'(q_a); q_o[1] = 32'(q_b); q_o[2] = 32'(q_c);
    ov_o[0] = ov_a; ov_o[1] = ov_b; ov_o[2] = ov_c;
    wr_o[0] = wr_a; wr_o[1] = wr_b; wr_o[2] = wr_c;
    zf_o[0] = zf_a; zf_o[1] = zf_b; zf_o[2] = zf_c;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("q[%0d]", i), q_o[i], m_state[i]);
      check($sformatf("wrap[%0d]", i), 32'(wr_o[i]), 32'(m_wrap[i]));
      check($sformatf("zero_fix[%0d]", i), 32'(zf_o[i]), 32'(m_zf[i]));
      check($sformatf("out_valid[%0d]", i), 32'(ov_o[i]), 32'(en & ~load));
      check($sformatf("nonzero[%0d]", i), 32'(q_o[i] != 0), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] seq_a[5] = '{16'h00FF, 16'h01FE, 16'h03FC, 16'h07F8, 16'h0FF1};
  int wrap_cnt_a, wrap_at_a, wrap_cnt_b, wrap_at_b, wrap_cnt_c, wrap_at_c;

  initial begin
    rst = 1'b0; en = 1'b1; load = 1'b0; load_data = 16'h0000; out_ready = 1'b0;

    // Reset state and out_valid tracking en & ~load during reset.
    @(negedge clk);
    check("rst_q", 32'(q_a), 32'h00FF);
    check("rst_wrap", 32'(wr_a), 32'd0);
    check("rst_zf", 32'(zf_a), 32'd0);
    check("rst_ov_en", 32'(ov_a), 32'd1);
    #1 load = 1'b1;
    #1 check("rst_ov_load", 32'(ov_a), 32'd0);

    // Release reset, continuous handshake: reference sequence literals.
    tick();
    rst = 1'b1; load = 1'b0; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("seq_a%0d", i), 32'(q_a), 32'(seq_a[i]));
      check($sformatf("seq_wrap%0d", i), 32'(wr_a), 32'd0);
      if (i == 1) check("step4_first", 32'(q_b), 32'h0FF1);
    end

    // Random stalls and occasional disable.
    for (int i = 0; i < 400; i++) begin
      tick();
      out_ready = 1'($urandom_range(0, 1));
      en = (i % 50 < 45);
    end

    // Zero load with en low: SEED substituted and zero_fix pulses once.
    tick();
    en = 1'b0; load = 1'b1; load_data = 16'h0000;
    tick();
    load = 1'b0; en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("zload_q", 32'(q_a), 32'h00FF);
    check("zload_zf", 32'(zf_a), 32'd1);
    check("zload_qc", 32'(q_c), 32'h01);

    // Full 16-bit period: exactly one wrap, on advance 65535, back to SEED.
    wrap_cnt_a = 0; wrap_at_a = 0; wrap_cnt_b = 0; wrap_at_b = 0;
    for (int i = 1; i <= 65535; i++) begin
      @(negedge clk);
      if (i == 1) check("zload_zf_drop", 32'(zf_a), 32'd0);
      if (wr_a) begin wrap_cnt_a++; wrap_at_a = i; end
      if (wr_b) begin wrap_cnt_b++; wrap_at_b = i; end
    end
    check("wrap_a_count", 32'(wrap_cnt_a), 32'd1);
    check("wrap_a_at", 32'(wrap_at_a), 32'd65535);
    check("wrap_a_q", 32'(q_a), 32'h00FF);
    check("wrap_b_count", 32'(wrap_cnt_b), 32'd1);
    check("wrap_b_at", 32'(wrap_at_b), 32'd65535);

    // Load during a handshake: load wins, start register moves.
    tick();
    load = 1'b1; load_data = 16'h1234;
    @(negedge clk);
    check("ld_ov", 32'(ov_a), 32'd0);
    tick();
    load = 1'b0;
    @(negedge clk);
    check("ld_q", 32'(q_a), 32'h1234);
    check("ld_zf", 32'(zf_a), 32'd0);
    check("ld_qc", 32'(q_c), 32'h34);
    wrap_cnt_c = 0; wrap_at_c = 0;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      if (wr_c) begin wrap_cnt_c++; wrap_at_c = i; end
    end
    check("wrap_c_count", 32'(wrap_cnt_c), 32'd1);
    check("wrap_c_at", 32'(wrap_at_c), 32'd255);
    check("wrap_c_q", 32'(q_c), 32'h34);

    // Reset mid-stall together with a load: immediate, load discarded.
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0; load = 1'b1; load_data = 16'h5555;
    #1;
    check("mrst_q", 32'(q_a), 32'h00FF);
    check("mrst_qc", 32'(q_c), 32'h01);
    check("mrst_wrap", 32'(wr_a), 32'd0);
    check("mrst_zf", 32'(zf_a), 32'd0);
    tick();
    rst = 1'b1; load = 1'b0;
    @(negedge clk);
    check("mrst_hold", 32'(q_a), 32'h00FF);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("mrst_resume", 32'(q_a), 32'h0FF1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
